// File: rtl/apb_master_bridge_if.sv
// Command/response port and APB requester bus of the bridge, in one bundle.
// master = bridge side, slave = command source plus APB slave side.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_timeout;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: one command -> SETUP/ACCESS -> one response strobe.
// Latency: response 3 cycles after accept plus one per PREADY wait state, capped by TIMEOUT.
// Backpressure: cmd_ready low while a transfer is in flight; responses cannot be stalled.
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_bridge_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d    = bus.cmd_write;
                    paddr_d     = bus.cmd_addr;
                    pwdata_d    = bus.cmd_wdata;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                // PREADY on the final allowed cycle still completes normally.
                if (bus.PREADY || (wait_cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = !bus.PREADY;
                    rsp_rdata_d   = (bus.PREADY && !pwrite_q) ? bus.PRDATA : '0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    cmd_ready_d   = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule
